fifo_wr_arbiter: RTL and testbench

Write-side arbiter and space scheduler for the compression core's multi-byte byte FIFO. Two producers share the FIFO's single multi-byte write port: requester A (control-word path) and requester B (literal/copy item path). The block grants the port round-robin, locks the grant for multi-beat packets, and accepts a write only when the FIFO has room. Writes are issued to the FIFO one cycle after acceptance.

---
 rtl/fifo_wr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: write-side arbiter and space scheduler for the byte FIFO.
// Requester A (control words) and requester B (literal/copy items) share the
// FIFO's single multi-byte write port. The grant alternates round-robin and is
// locked for multi-beat packets. A beat is accepted only when it fits in the
// free space, and the FIFO write is issued one cycle after acceptance.
// Optional build macro FIFO_WR_ARB_STATS_EN adds stall/grant counters.
//
// Handshake: a beat transfers on a rising edge when valid & ready are both
// high. Requesters hold valid, data, num_bytes and last stable until that
// edge. Ready never depends combinationally on data.
module fifo_wr_arbiter #(
   parameter int FIFO_SIZE    = 128,
   parameter int MAX_BYTES_IN = 16,
   parameter int CNT_W        = $clog2(MAX_BYTES_IN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [CNT_W-1:0] a_num_bytes,
   input  logic [7:0]       a_data [MAX_BYTES_IN],
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [CNT_W-1:0] b_num_bytes,
   input  logic [7:0]       b_data [MAX_BYTES_IN],
   input  logic             b_last,
   output logic             b_ready,
   input  logic [31:0]      fifo_occupancy,
   output logic             fifo_wr_en,
   output logic [CNT_W-1:0] fifo_num_bytes,
   output logic [7:0]       fifo_data [MAX_BYTES_IN],
   output logic             err_out,
`ifdef FIFO_WR_ARB_STATS_EN
   output logic [15:0]      stall_cnt,
   output logic [15:0]      grant_cnt_a,
   output logic [15:0]      grant_cnt_b,
`endif
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t state;
   logic   rr_last_b;   // 1: B was the last owner, so A wins the next tie

   logic             sel_b;
   logic             sel_valid;
   logic [CNT_W-1:0] sel_num;
   logic             sel_last;
   logic [CNT_W-1:0] inflight;
   logic [34:0]      free_u;
   logic signed [34:0] free_s;
   logic             fits;
   logic             illegal;
   logic             accept;

   assign state_dbg = state;

   // Pick the grantee: held owner when locked, otherwise round-robin among valids
   always_comb begin
      sel_b     = 1'b0;
      sel_valid = 1'b0;
      case (state)
         IDLE: begin
            if (a_valid && (!b_valid || rr_last_b)) begin
               sel_b     = 1'b0;
               sel_valid = 1'b1;
            end else if (b_valid) begin
               sel_b     = 1'b1;
               sel_valid = 1'b1;
            end
         end
         OWN_A: begin
            sel_b     = 1'b0;
            sel_valid = a_valid;
         end
         OWN_B: begin
            sel_b     = 1'b1;
            sel_valid = b_valid;
         end
         default: begin
            sel_b     = 1'b0;
            sel_valid = 1'b0;
         end
      endcase
   end

   assign sel_num  = sel_b ? b_num_bytes : a_num_bytes;
   assign sel_last = sel_b ? b_last : a_last;

   // The write issued last cycle has not reached fifo_occupancy yet, so it is
   // charged against free space here. Signed so an overfull FIFO blocks all.
   assign inflight = fifo_wr_en ? fifo_num_bytes : '0;
   assign free_u   = 35'(FIFO_SIZE) - {3'b000, fifo_occupancy} - 35'(inflight);
   assign free_s   = $signed(free_u);
   assign fits     = $signed(35'(sel_num)) <= free_s;
   assign illegal  = (sel_num == '0) || (sel_num > CNT_W'(MAX_BYTES_IN));

   // Illegal beats are always taken so a bad requester cannot wedge the port
   assign accept  = reset && sel_valid && (illegal || fits);
   assign a_ready = accept && !sel_b;
   assign b_ready = accept && sel_b;

   // Ownership, round-robin memory and the registered FIFO write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         rr_last_b      <= 1'b1;
         fifo_wr_en     <= 1'b0;
         fifo_num_bytes <= '0;
         fifo_data      <= '{default: 8'h00};
         err_out        <= 1'b0;
      end else begin
         if (accept) begin
            if (illegal) begin
               fifo_wr_en <= 1'b0;
               err_out    <= 1'b1;
            end else begin
               fifo_wr_en     <= 1'b1;
               fifo_num_bytes <= sel_num;
               if (sel_b) fifo_data <= b_data;
               else       fifo_data <= a_data;
            end
            if (sel_last) begin
               state     <= IDLE;
               rr_last_b <= sel_b;
            end else begin
               state <= sel_b ? OWN_B : OWN_A;
            end
         end else begin
            fifo_wr_en <= 1'b0;
            // A blocked winner keeps the grant so large beats cannot starve
            if (state == IDLE && sel_valid) state <= sel_b ? OWN_B : OWN_A;
         end
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   // Saturating activity counters for performance monitoring
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt   <= '0;
         grant_cnt_a <= '0;
         grant_cnt_b <= '0;
      end else begin
         if (sel_valid && !illegal && !fits && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (a_ready && grant_cnt_a != 16'hFFFF)
            grant_cnt_a <= grant_cnt_a + 16'd1;
         if (b_ready && grant_cnt_b != 16'hFFFF)
            grant_cnt_b <= grant_cnt_b + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios followed by randomized
// traffic, all compared against a transaction-level model of the arbiter.
module tb_fifo_wr_arbiter;

   localparam int FIFO_SIZE = 128;
   localparam int MAXB      = 16;
   localparam int CNT_W     = 5;
   localparam int CW        = 133;

   logic             clk;
   logic             reset;
   logic             a_valid, b_valid, a_last, b_last;
   logic [CNT_W-1:0] a_num_bytes, b_num_bytes;
   logic [7:0]       a_data [MAXB];
   logic [7:0]       b_data [MAXB];
   logic             a_ready, b_ready;
   logic [31:0]      fifo_occupancy;
   logic             fifo_wr_en;
   logic [CNT_W-1:0] fifo_num_bytes;
   logic [7:0]       fifo_data [MAXB];
   logic             err_out;
   logic [1:0]       state_dbg;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0]      stall_cnt, grant_cnt_a, grant_cnt_b;
`endif

   fifo_wr_arbiter #(.FIFO_SIZE(FIFO_SIZE), .MAX_BYTES_IN(MAXB), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_num_bytes(a_num_bytes), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
      .b_valid(b_valid), .b_num_bytes(b_num_bytes), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
      .fifo_occupancy(fifo_occupancy), .fifo_wr_en(fifo_wr_en), .fifo_num_bytes(fifo_num_bytes),
      .fifo_data(fifo_data), .err_out(err_out),
`ifdef FIFO_WR_ARB_STATS_EN
      .stall_cnt(stall_cnt), .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b),
`endif
      .state_dbg(state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard and counters
   logic [CW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   // Reference model: owner 0 = nobody, 1 = A, 2 = B
   int             m_owner;
   int             m_rr;
   bit             m_wr_en;
   bit             m_err;
   logic [CNT_W-1:0] m_num;
   logic [127:0]   m_data;
   bit             acc_a, acc_b;
   bit             got_a, got_b;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [127:0] pack(input logic [7:0] d [MAXB]);
      logic [127:0] p;
      for (int i = 0; i < MAXB; i++) p[i*8 +: 8] = d[i];
      return p;
   endfunction

   task automatic model_reset();
      m_owner = 0;
      m_rr    = 2;
      m_wr_en = 0;
      m_err   = 0;
      m_num   = '0;
      m_data  = '0;
      acc_a   = 0;
      acc_b   = 0;
      exp_q.delete();
   endtask

   // Registered outputs after an edge, compared to the model and the queue
   task automatic check_regs();
      logic [CW-1:0] front;
      check("wr_en", CW'(fifo_wr_en), CW'(m_wr_en));
      check("num_bytes", CW'(fifo_num_bytes), CW'(m_num));
      check("data", CW'(pack(fifo_data)), CW'(m_data));
      check("err_out", CW'(err_out), CW'(m_err));
      if (fifo_wr_en) begin
         if (exp_q.size() > 0) begin
            front = exp_q.pop_front();
            check("wr_beat", {fifo_num_bytes, pack(fifo_data)}, front);
         end else begin
            check("wr_unexpected", CW'(fifo_wr_en), CW'(0));
         end
      end
   endtask

   // One cycle: inputs are already set at the falling edge
   task automatic step();
      int free, win, n;
      bit v, l, bad, rdy;
      logic [127:0] d;
      #1;
      free = FIFO_SIZE - int'(fifo_occupancy) - (m_wr_en ? int'(m_num) : 0);
      if (m_owner != 0) win = m_owner;
      else if (a_valid && b_valid) win = (m_rr == 1) ? 2 : 1;
      else if (a_valid) win = 1;
      else if (b_valid) win = 2;
      else win = 0;
      v   = (win == 1) ? a_valid : (win == 2) ? b_valid : 1'b0;
      n   = (win == 2) ? int'(b_num_bytes) : int'(a_num_bytes);
      l   = (win == 2) ? b_last : a_last;
      d   = (win == 2) ? pack(b_data) : pack(a_data);
      bad = (n == 0) || (n > MAXB);
      rdy = (win != 0) && v && (bad || n <= free);
      got_a = a_ready;
      got_b = b_ready;
      check("a_ready", CW'(a_ready), CW'(win == 1 && rdy));
      check("b_ready", CW'(b_ready), CW'(win == 2 && rdy));
      acc_a = (win == 1) && rdy;
      acc_b = (win == 2) && rdy;
      if (rdy) begin
         if (bad) begin
            m_wr_en = 0;
            m_err   = 1;
         end else begin
            m_wr_en = 1;
            m_num   = CNT_W'(n);
            m_data  = d;
            exp_q.push_back({CNT_W'(n), d});
         end
         if (l) begin
            m_owner = 0;
            m_rr    = win;
         end else begin
            m_owner = win;
         end
      end else begin
         m_wr_en = 0;
         if (win != 0) m_owner = win;
      end
      @(posedge clk);
      @(negedge clk);
      check_regs();
   endtask

   // Asynchronous reset pulse applied away from the clock edge
   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check("rst_wr_en", CW'(fifo_wr_en), CW'(0));
      check("rst_num", CW'(fifo_num_bytes), CW'(0));
      check("rst_data", CW'(pack(fifo_data)), CW'(0));
      check("rst_err", CW'(err_out), CW'(0));
      check("rst_ready", CW'({a_ready, b_ready}), CW'(0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drive_a(input bit v, input int n, input bit l);
      a_valid = v;
      a_num_bytes = CNT_W'(n);
      a_last = l;
      for (int i = 0; i < MAXB; i++) a_data[i] = 8'($urandom);
   endtask

   task automatic drive_b(input bit v, input int n, input bit l);
      b_valid = v;
      b_num_bytes = CNT_W'(n);
      b_last = l;
      for (int i = 0; i < MAXB; i++) b_data[i] = 8'($urandom);
   endtask

   function automatic int rand_size();
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 31));
      return int'($urandom_range(1, MAXB));
   endfunction

   initial begin
      reset = 1'b0;
      fifo_occupancy = '0;
      drive_a(0, 1, 1);
      drive_b(0, 1, 1);
      @(negedge clk);
      do_reset();

      // Tie on an empty FIFO: A first, then B back-to-back
      drive_a(1, 4, 1);
      drive_b(1, 4, 1);
      step();
      check("tie_a_first", CW'(got_a), CW'(1));
      a_valid = 0;
      step();
      check("tie_b_next", CW'(got_b), CW'(1));
      check("tie_cnt", CW'(fifo_num_bytes), CW'(4));
      b_valid = 0;
      step();

      // A 3-beat packet locks out B until the last beat
      drive_b(1, 2, 1);
      drive_a(1, 2, 0);
      step();
      check("pkt_beat1", CW'(got_a), CW'(1));
      drive_a(1, 2, 0);
      step();
      check("pkt_b_locked1", CW'(got_b), CW'(0));
      drive_a(1, 2, 1);
      step();
      check("pkt_b_locked2", CW'(got_b), CW'(0));
      a_valid = 0;
      step();
      check("pkt_b_after", CW'(got_b), CW'(1));
      b_valid = 0;
      step();

      // Exact fit, then in-flight write leaves zero space
      fifo_occupancy = 32'd120;
      drive_b(1, 8, 1);
      step();
      check("exact_fit", CW'(got_b), CW'(1));
      b_valid = 0;
      drive_a(1, 1, 1);
      step();
      check("inflight_block", CW'(got_a), CW'(0));
      fifo_occupancy = 32'd128;
      step();
      check("full_block", CW'(got_a), CW'(0));
      fifo_occupancy = 32'd200;
      step();
      check("overfull_block", CW'(got_a), CW'(0));
      fifo_occupancy = 32'd127;
      step();
      check("drain_accept", CW'(got_a), CW'(1));
      a_valid = 0;
      fifo_occupancy = 32'd0;
      step();

      // Zero-size beat is consumed, dropped and flagged
      drive_b(1, 0, 1);
      step();
      check("illegal_ready", CW'(got_b), CW'(1));
      check("illegal_no_wr", CW'(fifo_wr_en), CW'(0));
      check("illegal_err", CW'(err_out), CW'(1));
      b_valid = 0;
      drive_a(1, 2, 1);
      step();
      check("post_err_accept", CW'(got_a), CW'(1));
      a_valid = 0;
      step();
      check("err_sticky", CW'(err_out), CW'(1));

      // Reset mid-packet in OWN_B with a write pending
      drive_b(1, 3, 0);
      step();
      check("midpkt_wr", CW'(fifo_wr_en), CW'(1));
      do_reset();
      drive_a(1, 5, 1);
      drive_b(1, 5, 1);
      step();
      check("post_rst_a_wins", CW'(got_a), CW'(1));
      a_valid = 0;
      b_valid = 0;
      step();

      // Random traffic honoring the hold-until-accepted rule
      acc_a = 1;
      acc_b = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            acc_a = 1;
            acc_b = 1;
         end
         if (!a_valid || acc_a) drive_a($urandom_range(0, 9) < 6, rand_size(), $urandom_range(0, 2) == 0);
         if (!b_valid || acc_b) drive_b($urandom_range(0, 9) < 6, rand_size(), $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) fifo_occupancy = 32'($urandom_range(0, 140));
         step();
      end

      // Drain and confirm every accepted beat was written
      a_valid = 0;
      b_valid = 0;
      step();
      step();
      check("queue_drained", CW'(exp_q.size()), CW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
